// File: rtl/board_vga_renderer.sv
// board_vga_renderer: per-frame snapshot of both 5x5 boards mapped to VGA colour, 2-clock pipeline.
// Optional fog of war on the PC board: define RENDER_HIDE_PC_SHIPS_EN.
module board_vga_renderer #(
  parameter int CELL_PX = 40,
  parameter int GRID_PX = 2,
  parameter int P_X0    = 80,
  parameter int PC_X0   = 360,
  parameter int Y0      = 140,
  parameter int CUR_PX  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] tablero_jugador [5][5],
  input  logic [1:0] tablero_pc [5][5],
  input  logic [2:0] i_actual,
  input  logic [2:0] j_actual,
  input  logic       cursor_en,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       blank_n
);
  localparam int PW = $clog2(CELL_PX);
  localparam logic [PW-1:0] CLAST = PW'(CELL_PX - 1);
  localparam logic [PW-1:0] GPX = PW'(GRID_PX);
  localparam logic [PW-1:0] CLO = PW'(GRID_PX + CUR_PX);
  localparam logic [PW-1:0] CHI = PW'(CELL_PX - CUR_PX);
  localparam logic [9:0] PX0 = 10'(P_X0);
  localparam logic [9:0] CX0 = 10'(PC_X0);
  localparam logic [9:0] YT = 10'(Y0);
  localparam logic [9:0] YB = 10'(Y0 + 5 * CELL_PX);
  logic [1:0] sh_p [5][5];
  logic [1:0] sh_c [5][5];
  logic [2:0] row, col, row_n, col_n;
  logic [PW-1:0] row_px, col_px, row_px_n, col_px_n;
  logic in_rows, in_cols, sel_pc, in_rows_n, in_cols_n, sel_pc_n;
  logic hs1, vs1, bl1;
  logic [1:0] code;
  logic grid, cur;
  logic [23:0] rgb_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_p <= '{default: '0};
      sh_c <= '{default: '0};
    end else if (vs1 && !vsync_in) begin
      sh_p <= tablero_jugador;
      sh_c <= tablero_pc;
    end
  // When the tracker is idle (before Y0 or after a reset) it reloads from fixed row boundaries.
  always_comb begin
    row_n = row;
    row_px_n = row_px;
    in_rows_n = in_rows;
    if (pix_x == '0) begin
      if (in_rows && pix_y != YT) begin
        row_px_n = row_px == CLAST ? '0 : row_px + 1'b1;
        row_n = row_px == CLAST && row != 3'd4 ? row + 3'd1 : row;
        in_rows_n = !(row_px == CLAST && row == 3'd4);
      end else begin
        in_rows_n = pix_y >= YT && pix_y < YB;
        for (int k = 0; k < 5; k++)
          if (pix_y >= 10'(Y0 + k * CELL_PX)) begin
            row_n = 3'(k);
            row_px_n = PW'(pix_y - 10'(Y0 + k * CELL_PX));
          end
      end
    end
  end
  always_comb begin
    col_n = col;
    col_px_n = col_px;
    in_cols_n = in_cols;
    sel_pc_n = sel_pc;
    if (pix_x == PX0 || pix_x == CX0) begin
      col_n = '0;
      col_px_n = '0;
      in_cols_n = 1'b1;
      sel_pc_n = pix_x == CX0;
    end else if (in_cols) begin
      col_px_n = col_px == CLAST ? '0 : col_px + 1'b1;
      col_n = col_px == CLAST && col != 3'd4 ? col + 3'd1 : col;
      in_cols_n = !(col_px == CLAST && col == 3'd4);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {row, col, row_px, col_px} <= '0;
      {in_rows, in_cols, sel_pc} <= '0;
      {hs1, vs1, bl1} <= 3'b110;
    end else begin
      {row, col, row_px, col_px} <= {row_n, col_n, row_px_n, col_px_n};
      {in_rows, in_cols, sel_pc} <= {in_rows_n, in_cols_n, sel_pc_n};
      {hs1, vs1, bl1} <= {hsync_in, vsync_in, video_on};
    end
  always_comb begin
    code = sel_pc ? sh_c[row][col] : sh_p[row][col];
`ifdef RENDER_HIDE_PC_SHIPS_EN
    code = sel_pc && code == 2'b01 ? 2'b00 : code;
`endif
    grid = row_px < GPX || col_px < GPX;
    cur = cursor_en && sel_pc && i_actual == row && j_actual == col &&
          (row_px < CLO || col_px < CLO || row_px >= CHI || col_px >= CHI);
    rgb_n = !bl1 || !in_rows || !in_cols || grid ? 24'h000000 :
            cur ? 24'hFFFF00 :
            code == 2'b00 ? 24'h0000FF :
            code == 2'b01 ? 24'h00FF00 :
            code == 2'b10 ? 24'hFF0000 : 24'h808080;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {red, green, blue} <= '0;
      {hsync_out, vsync_out, blank_n} <= 3'b110;
    end else begin
      {red, green, blue} <= rgb_n;
      {hsync_out, vsync_out, blank_n} <= {hs1, vs1, bl1};
    end
endmodule

// File: doc/board_vga_renderer.md
Name: board_vga_renderer

Overview:
- Reader side of the game-board interface: converts the 5x5 player and PC board arrays into VGA pixel colour.
- Sits between the board-state block and the VGA sync generator.
- Snapshots both boards once per frame, then maps raster coordinates to cells with running counters (no dividers).
- Pipelined, with sync signals delayed to match.

Parameters:
- CELL_PX, 40, cell edge in pixels (>= 8).
- GRID_PX, 2, grid-line thickness at the top and left edge of each cell.
- P_X0, 80, left x of the player board.
- PC_X0, 360, left x of the PC board (must be >= P_X0 + 5*CELL_PX).
- Y0, 140, top y of both boards.
- CUR_PX, 3, cursor border thickness.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous active-high reset.
- pix_x  in  10  current pixel column from the sync generator.
- pix_y  in  10  current pixel row.
- video_on  in  1  active-area flag.
- hsync_in  in  1  active-low hsync.
- vsync_in  in  1  active-low vsync.
- tablero_jugador  in  2x[5][5]  player board codes.
- tablero_pc  in  2x[5][5]  PC board codes.
- i_actual  in  3  cursor row.
- j_actual  in  3  cursor column.
- cursor_en  in  1  draw the cursor on the PC board.
- red, green, blue  out  8 each  pixel colour.
- hsync_out, vsync_out  out  1  syncs delayed to match colour.
- blank_n  out  1  video_on delayed.

Behaviour:
- Cell codes:
  - 00 AGUA -> blue (00,00,FF).
  - 01 BARCO -> green (00,FF,00).
  - 10 ATACA_BARCO -> red (FF,00,00).
  - 11 ATACA_AGUA -> grey (80,80,80).
  - Grid lines -> black. Cursor -> yellow (FF,FF,00).
  - Outside both boards -> black. blank_n=0 forces all colour outputs to 0.
- Frame snapshot:
  - Both arrays are copied into internal shadow registers on the cycle in which the registered vsync_in goes 1->0.
  - Rendering uses only the shadow copy, so the board never tears mid-frame.
  - Board changes during a frame appear starting with the next frame.
- Row tracker: updated on cycles where pix_x==0.
  - pix_y==Y0: row_px=0, row=0, in_rows=1.
  - Otherwise, if in_rows: row_px++. At row_px==CELL_PX-1, row_px wraps to 0 and row++.
  - row reaching 5 clears in_rows.
- Column tracker: identical scheme on every cycle.
  - Restarts (col_px=0, col=0) when pix_x==P_X0 or pix_x==PC_X0.
  - Selects board P or PC accordingly; in_cols clears when col reaches 5.
- Pipeline (latency 2 clocks from pix_x/pix_y/syncs to outputs):
  - S1: update trackers; register board select, row/col, row_px/col_px, region flags.
  - S2: fetch the shadow code; evaluate grid (row_px<GRID_PX or col_px<GRID_PX) and cursor; register RGB.
  - hsync_out, vsync_out and blank_n pass through a matching 2-stage delay.
- Colour priority: blank > outside board > grid > cursor > cell code.
- Cursor:
  - PC board only; requires cursor_en=1 and (row,col)==(i_actual,j_actual).
  - Drawn only on pixels within CUR_PX of the cell's inner edges (just inside the grid line). The cell interior keeps the code colour.
  - i_actual or j_actual >4: no cursor drawn.
- Boundaries:
  - Last board pixel is x=P_X0+5*CELL_PX-1; the next pixel is background.
  - Bottom row ends at y=Y0+5*CELL_PX-1.
- Reset:
  - Shadow boards = AGUA; trackers cleared (in_rows=in_cols=0).
  - Pipeline registers cleared; RGB=0; blank_n=0.
  - hsync_out=vsync_out=1 (inactive).
  - Reset mid-frame: rendering resumes correctly from the next line (row) and next board start (column). The first snapshot occurs on the next vsync fall.

Optional Feature:
- Macro RENDER_HIDE_PC_SHIPS_EN.
- Defined: PC-board cells with code BARCO are drawn blue, as AGUA (fog of war). ATACA_BARCO is still red. Player board is unaffected.
- Undefined: all codes are drawn with their true colours on both boards.

Test Plan:
- Reset, then one frame with the generator free-running, all boards AGUA -> pixel (P_X0+20, Y0+20) is (00,00,FF) two clocks after presentation; pixel (0,0) is (00,00,00); syncs are delayed exactly 2 clocks.
- Player[2][3]=01 loaded mid-frame -> still blue in the current frame. Next frame, pixel (P_X0+3*40+20, Y0+2*40+20) is green; pixel (P_X0+3*40, Y0+2*40) is black (grid).
- PC[4][4]=10, PC[0][0]=11 -> (PC_X0+180, Y0+180) red; (PC_X0+20, Y0+20) grey; (PC_X0+200, Y0+180) black (outside).
- cursor_en=1, i_actual=1, j_actual=2, PC[1][2]=00 -> (PC_X0+82, Y0+42) yellow; (PC_X0+100, Y0+60) blue. cursor_en=0 -> both blue.
- PC[3][1]=01 -> green without RENDER_HIDE_PC_SHIPS_EN, blue with it; player[3][1]=01 green in both builds.
- Assert rst for 5 clocks mid-line at y=Y0+100 -> outputs black with syncs high during reset. After release, board rows render correctly from the next line; no X on any output.
